// File: rtl/serial_receiver.sv
// serial_receiver: recovers DATA_BITS-wide payloads from start/data/parity/stop
// frames arriving one bit per clock, flags parity and framing errors, and keeps
// saturating error counters.
module serial_receiver #(
  parameter int DATA_BITS = 7,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 serial_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy,
  output logic [CNT_W-1:0]     parity_err_cnt,
  output logic [CNT_W-1:0]     frame_err_cnt
);

  localparam int BCW = $clog2(DATA_BITS + 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t               state_q, state_d;
  logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_q;

  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 perr_q;
  logic                 ferr_q;
  logic [CNT_W-1:0]     pcnt_q;
  logic [CNT_W-1:0]     fcnt_q;

  logic                 frame_done;
  logic                 perr_now;
  logic                 ferr_now;

  // Increment by one unless disabled or already at all-ones; never wraps.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic             en);
    if (en && (v != {CNT_W{1'b1}})) begin
      return v + CNT_W'(1);
    end
    return v;
  endfunction

  // The stop bit is on the line while in STOP; the frame is judged on that edge.
  assign frame_done = (state_q == STOP);
  assign perr_now   = (^shift_q) ^ par_q;
  assign ferr_now   = ~serial_in;

  // FSM state and bit counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  // Next-state logic; WAIT_HIGH keeps a stuck-low line from re-triggering.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (!serial_in) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        bit_cnt_d = bit_cnt_q + BCW'(1);
        if (bit_cnt_q == LAST_BIT) begin
          state_d = PARITY;
        end
      end
      PARITY: begin
        state_d = STOP;
      end
      STOP: begin
        state_d = serial_in ? IDLE : WAIT_HIGH;
      end
      WAIT_HIGH: begin
        if (serial_in) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Payload shifter (LSB arrives first) and parity-bit capture; data only, no reset.
  always_ff @(posedge clk) begin
    if (state_q == DATA) begin
      shift_q <= {serial_in, shift_q[DATA_BITS-1:1]};
    end
    if (state_q == PARITY) begin
      par_q <= serial_in;
    end
  end

  // Result registers and error counters, all updated at the end of the stop cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      pcnt_q  <= '0;
      fcnt_q  <= '0;
    end else begin
      valid_q <= frame_done;
      if (frame_done) begin
        data_q <= shift_q;
        perr_q <= perr_now;
        ferr_q <= ferr_now;
        pcnt_q <= sat_inc(pcnt_q, perr_now);
        fcnt_q <= sat_inc(fcnt_q, ferr_now);
      end
    end
  end

  assign data_out       = data_q;
  assign valid          = valid_q;
  assign parity_err     = perr_q;
  assign frame_err      = ferr_q;
  assign busy           = (state_q != IDLE);
  assign parity_err_cnt = pcnt_q;
  assign frame_err_cnt  = fcnt_q;

endmodule

// File: tb/tb_serial_receiver.sv
// Scoreboard bench for serial_receiver: a stimulus process sends frames and
// queues the expected result; a monitor pops and compares on each valid pulse.
module tb_serial_receiver;

  localparam int DB = 7;
  localparam int CW = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          serial_in = 1'b1;
  logic [DB-1:0] data_out;
  logic          valid;
  logic          parity_err;
  logic          frame_err;
  logic          busy;
  logic [CW-1:0] parity_err_cnt;
  logic [CW-1:0] frame_err_cnt;

  typedef struct {
    int data;
    int perr;
    int ferr;
    int pcnt;
    int fcnt;
    int busy;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   model_pcnt = 0;
  int   model_fcnt = 0;

  serial_receiver #(.DATA_BITS(DB), .CNT_W(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .serial_in     (serial_in),
    .data_out      (data_out),
    .valid         (valid),
    .parity_err    (parity_err),
    .frame_err     (frame_err),
    .busy          (busy),
    .parity_err_cnt(parity_err_cnt),
    .frame_err_cnt (frame_err_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input logic b);
    @(posedge clk);
    #1 serial_in = b;
  endtask

  // Send one frame; parity is even parity unless bad_par flips it. A zero stop
  // bit is followed by hold_low extra zeros and then a one; a good stop bit is
  // followed by gap idle ones.
  task automatic send_frame(input logic [DB-1:0] d, input logic bad_par,
                            input logic stop, input int gap);
    exp_t e;
    int   start_cyc;
    logic p;
    p = logic'($countones(d) % 2) ^ bad_par;
    drive(1'b0);
    start_cyc = cyc;
    for (int i = 0; i < DB; i++) drive(d[i]);
    drive(p);
    drive(stop);
    e.perr = (($countones(d) + int'(p)) % 2 != 0) ? 1 : 0;
    e.ferr = stop ? 0 : 1;
    if (e.perr != 0 && model_pcnt < CMAX) model_pcnt++;
    if (e.ferr != 0 && model_fcnt < CMAX) model_fcnt++;
    e.data = int'(d);
    e.pcnt = model_pcnt;
    e.fcnt = model_fcnt;
    e.busy = stop ? 0 : 1;
    e.cyc  = start_cyc + DB + 3;
    exp_q.push_back(e);
    if (!stop) begin
      for (int i = 0; i < gap; i++) drive(1'b0);
      drive(1'b1);
    end else begin
      for (int i = 0; i < gap; i++) drive(1'b1);
    end
  endtask

  // Monitor: every valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("valid_cycle", cyc, e.cyc);
        chk("data_out", int'(data_out), e.data);
        chk("parity_err", int'(parity_err), e.perr);
        chk("frame_err", int'(frame_err), e.ferr);
        chk("parity_err_cnt", int'(parity_err_cnt), e.pcnt);
        chk("frame_err_cnt", int'(frame_err_cnt), e.fcnt);
        chk("busy_in_valid", int'(busy), e.busy);
      end
    end
  end

  initial begin
    int w;
    logic [DB-1:0] d7f;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data_out", int'(data_out), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_parity_err", int'(parity_err), 0);
    chk("rst_frame_err", int'(frame_err), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_pcnt", int'(parity_err_cnt), 0);
    chk("rst_fcnt", int'(frame_err_cnt), 0);
    rst = 1'b0;
    repeat (2) drive(1'b1);

    // Single clean frame.
    send_frame(7'h55, 1'b0, 1'b1, 3);
    // Back-to-back frames with no idle gap.
    send_frame(7'h01, 1'b0, 1'b1, 0);
    send_frame(7'h6D, 1'b0, 1'b1, 3);
    // Parity error.
    send_frame(7'h12, 1'b1, 1'b1, 3);
    // Framing error with the line held low for 5 more cycles.
    send_frame(7'h3C, 1'b0, 1'b0, 5);
    repeat (4) drive(1'b1);

    // Reset during data bit 3 of 7'h7F.
    d7f = 7'h7F;
    drive(1'b0);
    for (int i = 0; i < 3; i++) drive(d7f[i]);
    @(posedge clk);
    #1 begin
      rst = 1'b1;
      serial_in = d7f[3];
    end
    @(posedge clk);
    #1 begin
      rst = 1'b0;
      serial_in = 1'b1;
    end
    model_pcnt = 0;
    model_fcnt = 0;
    chk("midrst_data_out", int'(data_out), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_pcnt", int'(parity_err_cnt), 0);
    chk("midrst_fcnt", int'(frame_err_cnt), 0);
    repeat (2) drive(1'b1);
    send_frame(7'h2A, 1'b0, 1'b1, 2);

    // Randomized mix of clean and erroneous frames.
    for (int n = 0; n < 60; n++) begin
      send_frame(DB'($urandom_range(0, (1 << DB) - 1)),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 9) != 0),
                 int'($urandom_range(0, 3)));
    end

    // Saturation: 300 bad-parity frames back to back.
    for (int n = 0; n < 300; n++) begin
      send_frame(DB'($urandom_range(0, (1 << DB) - 1)), 1'b1, 1'b1, 0);
    end
    repeat (2) drive(1'b1);

    w = 0;
    while (exp_q.size() != 0 && w < 50) begin
      @(posedge clk);
      w++;
    end
    chk("pending_expectations", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("sat_pcnt", int'(parity_err_cnt), CMAX);
    chk("final_fcnt", int'(frame_err_cnt), model_fcnt);
    chk("idle_busy", int'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
